// File: rtl/fetch_decode_execute.sv
// rtl/fetch_decode_execute.sv - fetch PC, decode fields + register file, execute ALU with forwarding
module fetch_decode_execute #(
  parameter int WIDTH            = 32,
  parameter int REGNUM           = 16,
  parameter int ADDRESSWIDTH     = 4,
  parameter int OPCODEWIDTH      = 4,
  parameter int INSTRUCTIONWIDTH = 24
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        fetch_en,
  input  logic                        take_branch,
  input  logic [WIDTH-1:0]            new_pc,
  output logic [WIDTH-1:0]            pc,
  output logic [WIDTH-1:0]            pc_plus1,
  input  logic [INSTRUCTIONWIDTH-1:0] instr,
  input  logic                        wb_we,
  input  logic [ADDRESSWIDTH-1:0]     wb_addr,
  input  logic [WIDTH-1:0]            wb_data,
  output logic [WIDTH-1:0]            rd1_data,
  output logic [WIDTH-1:0]            rd2_data,
  output logic [WIDTH-1:0]            imm,
  output logic [ADDRESSWIDTH-1:0]     rd_addr,
  output logic [ADDRESSWIDTH-1:0]     rs1_addr,
  output logic [ADDRESSWIDTH-1:0]     rs2_addr,
  output logic [OPCODEWIDTH-1:0]      opcode,
  input  logic [WIDTH-1:0]            e_rd1,
  input  logic [WIDTH-1:0]            e_rd2,
  input  logic [WIDTH-1:0]            e_imm,
  input  logic [WIDTH-1:0]            fwd_m,
  input  logic [WIDTH-1:0]            fwd_wb,
  input  logic [2:0]                  alu_ctrl,
  input  logic                        src2_imm,
  input  logic [1:0]                  fwd1_sel,
  input  logic [1:0]                  fwd2_sel,
  output logic [WIDTH-1:0]            reg2_final,
  output logic [WIDTH-1:0]            alu_out,
  output logic                        n,
  output logic                        z,
  output logic                        v,
  output logic                        c
);

  localparam logic [ADDRESSWIDTH-1:0] PCREG = ADDRESSWIDTH'(15);

  logic [WIDTH-1:0] regFile [REGNUM];
  logic [WIDTH-1:0] aOp;
  logic [WIDTH-1:0] bOp;
  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   subDiff;

  // PC register: branch target or sequential, only when fetch is enabled
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= '0;
    end else if (fetch_en) begin
      pc <= take_branch ? new_pc : pc_plus1;
    end
  end

  assign pc_plus1 = pc + WIDTH'(1);

  assign opcode   = instr[23:20];
  assign rd_addr  = instr[19:16];
  assign rs1_addr = instr[15:12];
  assign rs2_addr = instr[11:8];
  assign imm      = {{(WIDTH-12){instr[11]}}, instr[11:0]};

  // Register file write; R15 is the PC alias so it is never stored
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGNUM; i++) begin
        regFile[i] <= '0;
      end
    end else if (wb_we && (wb_addr != PCREG)) begin
      regFile[wb_addr] <= wb_data;
    end
  end

  // Register reads: R15 returns pc_plus1, otherwise bypass a same-cycle write
  always_comb begin
    rd1_data = regFile[rs1_addr];
    rd2_data = regFile[rs2_addr];
    if (rs1_addr == PCREG) begin
      rd1_data = pc_plus1;
    end else if (wb_we && (wb_addr == rs1_addr)) begin
      rd1_data = wb_data;
    end
    if (rs2_addr == PCREG) begin
      rd2_data = pc_plus1;
    end else if (wb_we && (wb_addr == rs2_addr)) begin
      rd2_data = wb_data;
    end
  end

  // Operand forwarding muxes and immediate select
  always_comb begin
    case (fwd1_sel)
      2'b01:   aOp = fwd_wb;
      2'b10:   aOp = fwd_m;
      default: aOp = e_rd1;
    endcase
    case (fwd2_sel)
      2'b01:   reg2_final = fwd_wb;
      2'b10:   reg2_final = fwd_m;
      default: reg2_final = e_rd2;
    endcase
    bOp = src2_imm ? e_imm : reg2_final;
  end

  assign addSum  = {1'b0, aOp} + {1'b0, bOp};
  assign subDiff = {1'b0, aOp} + {1'b0, ~bOp} + (WIDTH + 1)'(1);

  // ALU result and flags; carry/overflow only meaningful for add and sub
  always_comb begin
    alu_out = '0;
    c = 1'b0;
    v = 1'b0;
    case (alu_ctrl)
      3'b000: begin
        alu_out = addSum[WIDTH-1:0];
        c = addSum[WIDTH];
        v = (aOp[WIDTH-1] == bOp[WIDTH-1]) && (addSum[WIDTH-1] != aOp[WIDTH-1]);
      end
      3'b001: begin
        alu_out = subDiff[WIDTH-1:0];
        c = subDiff[WIDTH];
        v = (aOp[WIDTH-1] != bOp[WIDTH-1]) && (subDiff[WIDTH-1] != aOp[WIDTH-1]);
      end
      3'b010:  alu_out = aOp & bOp;
      3'b011:  alu_out = aOp | bOp;
      3'b100:  alu_out = aOp ^ bOp;
      3'b101:  alu_out = aOp << bOp[4:0];
      3'b110:  alu_out = aOp >> bOp[4:0];
      default: alu_out = bOp;
    endcase
    n = alu_out[WIDTH-1];
    z = (alu_out == '0);
  end

endmodule

// File: tb/tb_fetch_decode_execute.sv
// tb/tb_fetch_decode_execute.sv - directed self-checking bench for fetch_decode_execute
module tb_fetch_decode_execute;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        take_branch;
  logic [31:0] new_pc;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic [23:0] instr;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] rd1_data;
  logic [31:0] rd2_data;
  logic [31:0] imm;
  logic [3:0]  rd_addr;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [3:0]  opcode;
  logic [31:0] e_rd1;
  logic [31:0] e_rd2;
  logic [31:0] e_imm;
  logic [31:0] fwd_m;
  logic [31:0] fwd_wb;
  logic [2:0]  alu_ctrl;
  logic        src2_imm;
  logic [1:0]  fwd1_sel;
  logic [1:0]  fwd2_sel;
  logic [31:0] reg2_final;
  logic [31:0] alu_out;
  logic        n;
  logic        z;
  logic        v;
  logic        c;

  int errCount   = 0;
  int checkCount = 0;

  fetch_decode_execute dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en), .take_branch(take_branch),
    .new_pc(new_pc), .pc(pc), .pc_plus1(pc_plus1), .instr(instr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd1_data(rd1_data), .rd2_data(rd2_data), .imm(imm),
    .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .opcode(opcode),
    .e_rd1(e_rd1), .e_rd2(e_rd2), .e_imm(e_imm), .fwd_m(fwd_m), .fwd_wb(fwd_wb),
    .alu_ctrl(alu_ctrl), .src2_imm(src2_imm), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .reg2_final(reg2_final), .alu_out(alu_out), .n(n), .z(z), .v(v), .c(c)
  );

  always #5 clock = ~clock;

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic aluCase(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expOut,
                         input logic [3:0] expNzvc);
    alu_ctrl = op;
    e_rd1    = a;
    e_rd2    = b;
    fwd1_sel = 2'b00;
    fwd2_sel = 2'b00;
    src2_imm = 1'b0;
    #1;
    checkEq({tag, "_out"}, alu_out, expOut);
    checkEq({tag, "_nzvc"}, {28'd0, n, z, v, c}, {28'd0, expNzvc});
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; take_branch = 1'b0; new_pc = '0;
    instr = 24'h003F00; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    e_rd1 = '0; e_rd2 = '0; e_imm = '0; fwd_m = '0; fwd_wb = '0;
    alu_ctrl = 3'b000; src2_imm = 1'b0; fwd1_sel = 2'b00; fwd2_sel = 2'b00;

    tick();
    reset = 1'b0;
    #1;
    checkEq("reset_pc", pc, 32'd0);
    checkEq("reset_pc_plus1", pc_plus1, 32'd1);
    checkEq("reset_r3", rd1_data, 32'd0);
    checkEq("r15_after_reset", rd2_data, 32'd1);

    fetch_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkEq($sformatf("seq_pc%0d", i), pc, 32'(i));
      checkEq($sformatf("seq_pc_plus1_%0d", i), pc_plus1, 32'(i + 1));
    end

    take_branch = 1'b1; new_pc = 32'h40;
    tick();
    checkEq("branch_pc", pc, 32'h40);
    fetch_en = 1'b0; new_pc = 32'h80;
    tick();
    checkEq("stall_pc_hold", pc, 32'h40);
    take_branch = 1'b0;

    wb_we = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEAD;
    instr = 24'h003F00;
    #1;
    checkEq("bypass_rd1", rd1_data, 32'hDEAD);
    checkEq("r15_rd2", rd2_data, 32'h41);
    tick();
    wb_we = 1'b0;
    #1;
    checkEq("stored_rd1", rd1_data, 32'hDEAD);

    wb_we = 1'b1; wb_addr = 4'd15; wb_data = 32'h1234;
    #1;
    checkEq("r15_write_bypass_ignored", rd2_data, 32'h41);
    tick();
    wb_we = 1'b0;
    #1;
    checkEq("r15_write_ignored", rd2_data, 32'h41);

    wb_we = 1'b1; wb_addr = 4'd0; wb_data = 32'h55;
    tick();
    wb_we = 1'b0; instr = 24'h000300;
    #1;
    checkEq("r0_ordinary", rd1_data, 32'h55);
    checkEq("r3_rd2", rd2_data, 32'hDEAD);

    instr = 24'h213FFF;
    #1;
    checkEq("dec_opcode", {28'd0, opcode}, 32'd2);
    checkEq("dec_rd", {28'd0, rd_addr}, 32'd1);
    checkEq("dec_rs1", {28'd0, rs1_addr}, 32'd3);
    checkEq("dec_rs2", {28'd0, rs2_addr}, 32'hF);
    checkEq("dec_imm_neg", imm, 32'hFFFFFFFF);
    instr = 24'h0007FF;
    #1;
    checkEq("dec_imm_pos", imm, 32'h000007FF);

    aluCase("add_ovf",   3'b000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b1010);
    aluCase("add_carry", 3'b000, 32'hFFFFFFFF, 32'd1,        32'h00000000, 4'b0101);
    aluCase("sub_eq",    3'b001, 32'd5,        32'd5,        32'h00000000, 4'b0101);
    aluCase("sub_borrow",3'b001, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b1000);
    aluCase("sub_ovf",   3'b001, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b0011);
    aluCase("and",       3'b010, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000);
    aluCase("or",        3'b011, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 4'b0000);
    aluCase("xor",       3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100);
    aluCase("shl",       3'b101, 32'd1,        32'd33,       32'd2,        4'b0000);
    aluCase("shr",       3'b110, 32'h80000000, 32'd4,        32'h08000000, 4'b0000);
    aluCase("pass",      3'b111, 32'h12345678, 32'h80000000, 32'h80000000, 4'b1000);

    alu_ctrl = 3'b001; e_rd1 = 32'd100; e_rd2 = 32'd200;
    fwd1_sel = 2'b10; fwd_m = 32'd9; fwd2_sel = 2'b01; fwd_wb = 32'd4;
    src2_imm = 1'b0; e_imm = 32'd2;
    #1;
    checkEq("fwd_sub", alu_out, 32'd5);
    checkEq("fwd_reg2", reg2_final, 32'd4);
    src2_imm = 1'b1;
    #1;
    checkEq("imm_sub", alu_out, 32'd7);
    checkEq("imm_reg2", reg2_final, 32'd4);
    fwd1_sel = 2'b11; fwd2_sel = 2'b11; src2_imm = 1'b0; alu_ctrl = 3'b000;
    #1;
    checkEq("sel11_add", alu_out, 32'd300);
    checkEq("sel11_reg2", reg2_final, 32'd200);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
